// File: rtl/manchester_pkg.sv
// Shared types and bit-window helpers for the Manchester-to-NRZ decoder.
package manchester_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned SPB_DEFAULT = 8;

    // Earliest count accepted as a mid-bit edge.
    function automatic int unsigned mid_lo(input int unsigned spb);
        return (3 * spb) / 4;
    endfunction

    // Latest count accepted as a mid-bit edge.
    function automatic int unsigned mid_hi(input int unsigned spb);
        return (5 * spb) / 4;
    endfunction

    // Count at which a missing mid-bit edge ends the frame.
    function automatic int unsigned timeout_cnt(input int unsigned spb);
        return (3 * spb) / 2;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned spb);
        return $clog2(timeout_cnt(spb) + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a third flop for line-edge detection.
// The edge output carries a _c suffix because "edge" is a reserved word.
module sync_edge_det (
    input  logic clock,
    input  logic reset_b,
    input  logic d_in,
    output logic level,
    output logic edge_c
);

    logic q1, q2, q3;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
            q3 <= 1'b0;
        end else begin
            q1 <= d_in;
            q2 <= q1;
            q3 <= q2;
        end
    end

    assign level  = q2;
    assign edge_c = q2 ^ q3;

endmodule

// File: rtl/manchester_2_nrz_decoder.sv
// Manchester-to-NRZ decoder: locks on the first line edge, then tracks mid-bit edges.
// Define MANCH_ERR_DETECT_EN to enable code-violation detection on code_err.
module manchester_2_nrz_decoder
    import manchester_pkg::*;
#(
    parameter int unsigned SPB = SPB_DEFAULT
) (
    input  logic clock,
    input  logic reset_b,
    input  logic B_in,
    output logic B_out,
    output logic bit_valid,
    output logic locked,
    output logic code_err
);

    localparam int unsigned CW    = cnt_width(SPB);
    localparam logic [CW-1:0] LO_C  = CW'(mid_lo(SPB));
    localparam logic [CW-1:0] HI_C  = CW'(mid_hi(SPB));
    localparam logic [CW-1:0] TMO_C = CW'(timeout_cnt(SPB));

`ifdef MANCH_ERR_DETECT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          level, edge_c;
    state_t        state, state_n;
    logic [CW-1:0] c, c_n, c1;
    logic          bnd, bnd_n;
    logic          b_out_n, valid_n, err_n, locked_n;

    sync_edge_det u_sync (
        .clock   (clock),
        .reset_b (reset_b),
        .d_in    (B_in),
        .level   (level),
        .edge_c  (edge_c)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state     <= HUNT;
            c         <= '0;
            bnd       <= 1'b0;
            B_out     <= 1'b0;
            bit_valid <= 1'b0;
            code_err  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            c         <= c_n;
            bnd       <= bnd_n;
            B_out     <= b_out_n;
            bit_valid <= valid_n;
            code_err  <= err_n;
            locked    <= locked_n;
        end
    end

    // c1 is the number of clocks elapsed since the last decoded mid-bit edge.
    always_comb begin
        state_n = state;
        c_n     = '0;
        bnd_n   = 1'b0;
        b_out_n = B_out;
        valid_n = 1'b0;
        err_n   = 1'b0;
        c1      = c + CW'(1);

        case (state)
            HUNT: begin
                if (edge_c) begin
                    b_out_n = ~level;
                    valid_n = 1'b1;
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                c_n   = c1;
                bnd_n = bnd;
                if (c1 == TMO_C) begin
                    state_n = HUNT;
                    c_n     = '0;
                    bnd_n   = 1'b0;
                end else if (edge_c) begin
                    if (c1 < LO_C) begin
                        // One boundary edge per bit is legal; a second one is a violation.
                        if (ERR_EN && bnd) begin
                            err_n   = 1'b1;
                            state_n = HUNT;
                            c_n     = '0;
                            bnd_n   = 1'b0;
                        end else begin
                            bnd_n = 1'b1;
                        end
                    end else if (c1 <= HI_C) begin
                        b_out_n = ~level;
                        valid_n = 1'b1;
                        c_n     = '0;
                        bnd_n   = 1'b0;
                    end else if (ERR_EN) begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                        c_n     = '0;
                        bnd_n   = 1'b0;
                    end
                end
            end
        endcase

        locked_n = (state_n == LOCKED);
    end

endmodule

// File: tb/tb_manchester_2_nrz_decoder.sv
// Scoreboard bench for manchester_2_nrz_decoder (SPB=8); honours MANCH_ERR_DETECT_EN.
module tb_manchester_2_nrz_decoder;

    typedef struct {
        bit err;
        bit b;
        int cyc;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_b = 1'b1;
    logic B_in    = 1'b0;
    logic B_out, bit_valid, locked, code_err;

    int   cyc      = 0;
    int   last_mid = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    exp_t sbq[$];
    exp_t got;

    manchester_2_nrz_decoder #(.SPB(8)) dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .B_in      (B_in),
        .B_out     (B_out),
        .bit_valid (bit_valid),
        .locked    (locked),
        .code_err  (code_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every decode or error pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (bit_valid || code_err) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b B_out=%0b at cyc %0d, required no event",
                         bit_valid, code_err, B_out, cyc);
            end else begin
                got = sbq.pop_front();
                if (code_err !== got.err || bit_valid !== !got.err || cyc != got.cyc ||
                    (!got.err && B_out !== got.b)) begin
                    n_bad++;
                    $display("FAIL event: got valid=%0b err=%0b B_out=%0b cyc=%0d, required valid=%0b err=%0b B_out=%0b cyc=%0d",
                             bit_valid, code_err, B_out, cyc, !got.err, got.err, got.b, got.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0b required %0b", name, act, req);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic push_exp(input bit err, input bit b);
        exp_t e;
        e.err = err;
        e.b   = b;
        e.cyc = cyc + 3;
        sbq.push_back(e);
    endtask

    task automatic line_at(input int gap, input logic v);
        wait_until(last_mid + gap);
        B_in = v;
    endtask

    // Mid-bit edge "gap" clocks after the previous one, decoding as b.
    task automatic mid(input int gap, input bit b);
        line_at(gap, ~b);
        push_exp(1'b0, b);
        last_mid = cyc;
    endtask

    task automatic first_edge();
        B_in = 1'b1;
        push_exp(1'b0, 1'b0);
        last_mid = cyc;
    endtask

    task automatic send_bit(input bit b);
        if (B_in != b) line_at(4, b);
        mid(8, b);
        check("locked_in_frame", locked, 1'b1);
    endtask

    task automatic check_timeout();
        wait_until(last_mid + 14);
        check("locked_before_timeout", locked, 1'b1);
        @(negedge clock);
        check("locked_after_timeout", locked, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        B_in = 1'b0;
        #2 reset_b = 1'b0;
        #1;
        check("rst_B_out", B_out, 1'b0);
        check("rst_bit_valid", bit_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_code_err", code_err, 1'b0);
        repeat (3) @(negedge clock);
        reset_b = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        do_reset();

        // Frame 0,1,1,0,1 at nominal spacing, then end of frame.
        first_edge();
        check("locked_before_first_decode", locked, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_timeout();
        check("B_out_held_after_timeout", B_out, 1'b1);
        repeat (3) @(negedge clock);

        // Single edge then static line.
        first_edge();
        check_timeout();
        check("B_out_held_single", B_out, 1'b0);
        do_reset();

        // Jittered mid-bit edges at 6 and 10, then a late edge at 11.
        first_edge();
        mid(6, 1'b1);
        mid(10, 1'b0);
        line_at(11, 1'b0);
`ifdef MANCH_ERR_DETECT_EN
        push_exp(1'b1, 1'b0);
        wait_until(last_mid + 14);
        check("locked_after_late_err", locked, 1'b0);
`else
        check_timeout();
`endif
        repeat (4) @(negedge clock);

        // Edge coinciding with timeout is not decoded.
        first_edge();
        line_at(12, 1'b0);
        check_timeout();
        repeat (6) @(negedge clock);
        check("no_decode_on_tie", bit_valid, 1'b0);

        // Glitch: two boundary edges within one bit.
        first_edge();
        line_at(2, 1'b0);
        line_at(3, 1'b1);
`ifdef MANCH_ERR_DETECT_EN
        push_exp(1'b1, 1'b0);
        wait_until(last_mid + 7);
        check("locked_after_glitch", locked, 1'b0);
`else
        wait_until(last_mid + 7);
        check("locked_after_glitch", locked, 1'b1);
`endif
        mid(8, 1'b1);
        check_timeout();
        do_reset();

        // Reset in the middle of bit 3, then relock.
        first_edge();
        send_bit(1'b1);
        line_at(4, 1'b1);
        wait_until(last_mid + 6);
        check("pre_reset_B_out", B_out, 1'b1);
        check("pre_reset_locked", locked, 1'b1);
        do_reset();
        first_edge();
        send_bit(1'b1);
        check_timeout();
        repeat (4) @(negedge clock);

        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
